// File: rtl/signed_sar_search.sv
// Successive-approximation search that finds a signed 6-bit target using only a comparator.
// The search walks an offset code u = trial ^ 6'b100000 from MSB to LSB, one trial per settle window.
module signed_sar_search #(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic [5:0] cmp_trial,
  input  logic       cmp_greater,
  input  logic       cmp_smaller,
  input  logic       cmp_equal,
  output logic       busy,
  output logic       done,
  output logic [5:0] result,
  output logic [2:0] trials,
  output logic       err
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] TRIAL = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;
  localparam logic [2:0] SETTLE = 3'(SETTLE_CYCLES);
  localparam logic [5:0] MID    = 6'b100000;

  logic [1:0] state;
  logic [5:0] u;
  logic [2:0] k;
  logic [2:0] c;
  logic [5:0] u_upd;
  logic       one_hot;
  logic       sample;

  // Greater-only clears the bit under test; smaller-only leaves it set.
  always_comb begin
    u_upd   = cmp_greater ? (u & ~(6'd1 << k)) : u;
    one_hot = ({cmp_greater, cmp_smaller, cmp_equal} == 3'b100) ||
              ({cmp_greater, cmp_smaller, cmp_equal} == 3'b010) ||
              ({cmp_greater, cmp_smaller, cmp_equal} == 3'b001);
    sample  = (state == TRIAL) && (c == SETTLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      u      <= MID;
      k      <= 3'd5;
      c      <= 3'd0;
      result <= 6'd0;
      trials <= 3'd0;
      err    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state  <= TRIAL;
            u      <= MID;
            k      <= 3'd5;
            c      <= 3'd0;
            trials <= 3'd0;
            err    <= 1'b0;
          end
        end
        TRIAL: begin
          if (!sample) begin
            c <= c + 3'd1;
          end else begin
            trials <= trials + 3'd1;
            if (!one_hot) begin
              err    <= 1'b1;
              result <= cmp_trial;
              state  <= DONE;
            end else if (cmp_equal) begin
              result <= cmp_trial;
              state  <= DONE;
            end else if (k == 3'd0) begin
              // u is left untouched so the last trial stays visible during DONE.
              result <= u_upd ^ MID;
              state  <= DONE;
            end else begin
              u <= u_upd | (6'd1 << (k - 3'd1));
              k <= k - 3'd1;
              c <= 3'd0;
            end
          end
        end
        DONE: begin
          state <= IDLE;
          u     <= MID;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign cmp_trial = u ^ MID;
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);

endmodule

// File: tb/tb_signed_sar_search.sv
// Bench for signed_sar_search: three instances (settle 2, 0, 7), each wired to a behavioural comparator.
// Expected trial sequences come from a plain-integer binary-search model.
module tb_signed_sar_search;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [2:0]       start_v;
  logic [2:0]       fault_v;
  logic [2:0][5:0]  tgt_v;
  logic [2:0][5:0]  trial_v;
  logic [2:0]       g_v, s_v, e_v;
  logic [2:0]       busy_v, done_v, err_v;
  logic [2:0][5:0]  result_v;
  logic [2:0][2:0]  trials_v;

  int checks = 0;
  int fails  = 0;

  for (genvar i = 0; i < 3; i++) begin : g_dut
    // Comparator model; fault forces Greater and Smaller together.
    assign g_v[i] = fault_v[i] | ($signed(trial_v[i]) > $signed(tgt_v[i]));
    assign s_v[i] = fault_v[i] | ($signed(trial_v[i]) < $signed(tgt_v[i]));
    assign e_v[i] = ~fault_v[i] & (trial_v[i] == tgt_v[i]);

    signed_sar_search #(.SETTLE_CYCLES((i == 0) ? 2 : (i == 1) ? 0 : 7)) u_dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start_v[i]),
      .cmp_trial  (trial_v[i]),
      .cmp_greater(g_v[i]),
      .cmp_smaller(s_v[i]),
      .cmp_equal  (e_v[i]),
      .busy       (busy_v[i]),
      .done       (done_v[i]),
      .result     (result_v[i]),
      .trials     (trials_v[i]),
      .err        (err_v[i])
    );
  end

  // n-th trial value (1-based) of a binary search over -32..31 starting at 0.
  function automatic int trial_at(input int tgt, input int idx);
    int t;
    int step;
    t = 0;
    step = 16;
    for (int n = 1; n < idx; n++) begin
      t = (t > tgt) ? t - step : t + step;
      step = step / 2;
    end
    return t;
  endfunction

  function automatic int n_trials(input int tgt);
    for (int n = 1; n <= 6; n++)
      if (trial_at(tgt, n) == tgt) return n;
    return 6;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one search on the settle-2 instance, checking every trial and the DONE cycle.
  task automatic run0(input int tgt, input int fault_at, input int restart_at,
                      input int rst_at, input bit start_in_done, input string name);
    int exp_n;
    int exp_res;
    tgt_v[0] = 6'(tgt);
    exp_n    = (fault_at > 0) ? fault_at : n_trials(tgt);
    exp_res  = (fault_at > 0) ? trial_at(tgt, fault_at) : tgt;
    start_v[0] = 1'b1;
    tick();
    start_v[0] = 1'b0;
    for (int n = 1; n <= exp_n; n++) begin
      checks++;
      if (trial_v[0] !== 6'(trial_at(tgt, n)) || busy_v[0] !== 1'b1 || done_v[0] !== 1'b0) begin
        fails++;
        $display("FAIL %s trial %0d: cmp_trial=%0d busy=%b done=%b, want %0d busy=1 done=0",
                 name, n, $signed(trial_v[0]), busy_v[0], done_v[0], trial_at(tgt, n));
      end
      if (rst_at == n) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (busy_v[0] !== 1'b0 || done_v[0] !== 1'b0 || trial_v[0] !== 6'd0 ||
            result_v[0] !== 6'd0 || trials_v[0] !== 3'd0 || err_v[0] !== 1'b0) begin
          fails++;
          $display("FAIL %s reset: busy=%b done=%b trial=%h result=%h trials=%0d err=%b, want all 0",
                   name, busy_v[0], done_v[0], trial_v[0], result_v[0], trials_v[0], err_v[0]);
        end
        return;
      end
      if (fault_at == n) fault_v[0] = 1'b1;
      for (int c = 0; c < 3; c++) begin
        if (restart_at == n && c == 0) start_v[0] = 1'b1;
        tick();
        start_v[0] = 1'b0;
      end
      fault_v[0] = 1'b0;
    end
    checks++;
    if (done_v[0] !== 1'b1 || busy_v[0] !== 1'b1 || result_v[0] !== 6'(exp_res) ||
        trials_v[0] !== 3'(exp_n) || err_v[0] !== (fault_at > 0) ||
        trial_v[0] !== 6'(trial_at(tgt, exp_n))) begin
      fails++;
      $display("FAIL %s done: done=%b busy=%b result=%0d trials=%0d err=%b trial=%0d, want 1 1 %0d %0d %b %0d",
               name, done_v[0], busy_v[0], $signed(result_v[0]), trials_v[0], err_v[0],
               $signed(trial_v[0]), exp_res, exp_n, fault_at > 0, trial_at(tgt, exp_n));
    end
    if (start_in_done) start_v[0] = 1'b1;
    tick();
    start_v[0] = 1'b0;
    checks++;
    if (done_v[0] !== 1'b0 || busy_v[0] !== 1'b0 || trial_v[0] !== 6'd0 || result_v[0] !== 6'(exp_res)) begin
      fails++;
      $display("FAIL %s idle: done=%b busy=%b trial=%h result=%0d, want 0 0 00 %0d",
               name, done_v[0], busy_v[0], trial_v[0], $signed(result_v[0]), exp_res);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start_v = '0;
    fault_v = '0;
    tgt_v   = '0;
    repeat (3) tick();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (busy_v[i] !== 1'b0 || done_v[i] !== 1'b0 || trial_v[i] !== 6'd0 ||
          result_v[i] !== 6'd0 || trials_v[i] !== 3'd0 || err_v[i] !== 1'b0) begin
        fails++;
        $display("FAIL reset_state[%0d]: busy=%b done=%b trial=%h result=%h trials=%0d err=%b, want all 0",
                 i, busy_v[i], done_v[i], trial_v[i], result_v[i], trials_v[i], err_v[i]);
      end
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_target_zero();
    run0(0, 0, 0, 0, 1'b0, "target_zero");
  endtask

  task automatic test_directed();
    run0(-5, 0, 0, 0, 1'b0, "target_m5");
    run0(31, 0, 0, 0, 1'b0, "target_31");
    run0(-32, 0, 0, 0, 1'b0, "target_m32");
  endtask

  task automatic test_fault();
    run0(13, 3, 0, 0, 1'b0, "fault_3rd");
  endtask

  task automatic test_restart();
    run0(-20, 0, 2, 0, 1'b0, "restart_mid");
  endtask

  task automatic test_mid_reset();
    run0(7, 0, 0, 2, 1'b0, "mid_reset");
    run0(-1, 0, 0, 0, 1'b0, "after_reset");
  endtask

  task automatic test_back_to_back();
    run0(25, 0, 0, 0, 1'b1, "start_in_done");
    run0(-9, 0, 0, 0, 1'b0, "back_to_back");
  endtask

  task automatic test_random();
    for (int r = 0; r < 20; r++)
      run0(int'($urandom_range(0, 63)) - 32, 0, 0, 0, 1'b0, "random");
  endtask

  // All 64 targets on the settle-0 or settle-7 instance with a bounded wait for done.
  task automatic test_sweep(input int which);
    int cyc;
    for (int tgt = -32; tgt <= 31; tgt++) begin
      tgt_v[which]   = 6'(tgt);
      start_v[which] = 1'b1;
      tick();
      start_v[which] = 1'b0;
      cyc = 0;
      while (done_v[which] !== 1'b1 && cyc < 100) begin
        tick();
        cyc++;
      end
      checks++;
      if (cyc >= 100) begin
        fails++;
        $display("FAIL sweep[%0d] target %0d: no done within 100 cycles", which, tgt);
      end else if (result_v[which] !== 6'(tgt) || trials_v[which] !== 3'(n_trials(tgt)) ||
                   err_v[which] !== 1'b0) begin
        fails++;
        $display("FAIL sweep[%0d] target %0d: result=%0d trials=%0d err=%b, want %0d %0d 0",
                 which, tgt, $signed(result_v[which]), trials_v[which], err_v[which], tgt, n_trials(tgt));
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_target_zero();
    test_directed();
    test_fault();
    test_restart();
    test_mid_reset();
    test_back_to_back();
    test_random();
    test_sweep(1);
    test_sweep(2);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
